// File: rtl/bdir_line_ctrl.sv
// Half-duplex serial line controller: turns parallel read/write commands into
// MSB-first bit streams on a shared line, inserting guard cycles on direction change.
module bdir_line_ctrl #(
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [WIDTH-1:0] cmd_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             direction,
   output logic             data_out,
   input  logic             data_in,
   output logic             busy
);

   localparam int BW = $clog2(WIDTH);
   localparam int TW = $clog2(TURN_CYCLES + 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_TURN, S_TX, S_RX, S_RESP} state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_op_write;
   logic             r_last_write;
   logic [BW-1:0]    r_bitcnt;
   logic [TW-1:0]    r_turncnt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_rdata;
   logic             w_accept;
   logic             w_bit_last;
   logic             w_turn_last;
   logic [WIDTH-1:0] w_rx_word;

   assign w_accept    = cmd_valid && cmd_ready;
   assign w_bit_last  = (r_bitcnt == BIT_LAST);
   assign w_turn_last = (r_turncnt == TURN_LAST);
   assign w_rx_word   = {r_shift[WIDTH-2:0], data_in};

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (cmd_write != r_last_write) w_next = S_TURN;
               else if (cmd_write)            w_next = S_TX;
               else                           w_next = S_RX;
            end
         end
         S_TURN: if (w_turn_last) w_next = r_op_write ? S_TX : S_RX;
         S_TX:   if (w_bit_last)  w_next = S_IDLE;
         S_RX:   if (w_bit_last)  w_next = S_RESP;
         S_RESP: if (rsp_ready)   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // The line is only ever driven in TX, so RX/RESP/TURN all leave it released.
   always_comb begin
      cmd_ready = (r_state == S_IDLE) && rst_n;
      direction = (r_state == S_TX);
      data_out  = (r_state == S_TX) && r_shift[WIDTH-1];
      busy      = (r_state != S_IDLE);
      rsp_valid = (r_state == S_RESP);
      rsp_rdata = r_rdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op_write   <= 1'b0;
         r_last_write <= 1'b0;
         r_bitcnt     <= '0;
         r_turncnt    <= '0;
         r_rdata      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op_write <= cmd_write;
                  r_bitcnt   <= '0;
                  r_turncnt  <= '0;
               end
            end
            S_TURN: begin
               if (w_turn_last) begin
                  r_turncnt    <= '0;
                  r_last_write <= r_op_write;
               end else begin
                  r_turncnt <= r_turncnt + 1'b1;
               end
            end
            S_TX: begin
               if (w_bit_last) begin
                  r_bitcnt     <= '0;
                  r_last_write <= 1'b1;
               end else begin
                  r_bitcnt <= r_bitcnt + 1'b1;
               end
            end
            S_RX: begin
               if (w_bit_last) begin
                  r_bitcnt     <= '0;
                  r_last_write <= 1'b0;
                  r_rdata      <= w_rx_word;
               end else begin
                  r_bitcnt <= r_bitcnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Shared shift register: loaded with write data, shifted out in TX, shifted in during RX.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && w_accept) r_shift <= cmd_wdata;
      else if (r_state == S_TX)          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      else if (r_state == S_RX)          r_shift <= w_rx_word;
   end

endmodule

// File: tb/tb_bdir_line_ctrl.sv
// Directed bench for bdir_line_ctrl: per-cycle vector table plus hand-written
// sequences for response back-pressure and mid-transfer reset.
module tb_bdir_line_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_rdata;
   logic       direction;
   logic       data_out;
   logic       data_in;
   logic       busy;

   always #5 clk = ~clk;

   bdir_line_ctrl #(.WIDTH(8), .TURN_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .direction(direction), .data_out(data_out), .data_in(data_in), .busy(busy)
   );

   // exp = {direction, data_out, cmd_ready, busy, rsp_valid, rsp_rdata[7:0]}
   typedef struct {
      logic        rn, cv, cw;
      logic [7:0]  wd;
      logic        rr, din;
      logic [12:0] exp;
   } vec_t;

   vec_t vt[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   function automatic void add(input logic rn, cv, cw, input logic [7:0] wd, input logic rr, din,
                               input logic dir, dout, crdy, bsy, rv, input logic [7:0] rd);
      vec_t v;
      v.rn = rn; v.cv = cv; v.cw = cw; v.wd = wd; v.rr = rr; v.din = din;
      v.exp = {dir, dout, crdy, bsy, rv, rd};
      vt.push_back(v);
   endfunction

   function automatic logic [12:0] outs();
      return {direction, data_out, cmd_ready, busy, rsp_valid, rsp_rdata};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] pat;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_wdata = 8'h00;
      rsp_ready = 1'b0; data_in = 1'b0;
      tick();
      tick();

      // reset held, then idle
      add(0,0,0,8'h00,0,0, 0,0,0,0,0,8'h00);
      add(1,0,0,8'h00,0,0, 0,0,1,0,0,8'h00);
      // write 0xA5 after reset: turnaround then MSB-first bits
      add(1,1,1,8'hA5,0,0, 0,0,1,0,0,8'h00);
      for (int k = 0; k < 2; k++) add(1,0,0,8'h00,0,0, 0,0,0,1,0,8'h00);
      pat = 8'hA5;
      for (int k = 0; k < 8; k++) add(1,0,0,8'h00,0,0, 1,pat[7-k],0,1,0,8'h00);
      add(1,0,0,8'h00,0,0, 0,0,1,0,0,8'h00);
      // write 0x3C then 0xFF presented immediately: one idle cycle, no turnaround
      add(1,1,1,8'h3C,0,0, 0,0,1,0,0,8'h00);
      pat = 8'h3C;
      for (int k = 0; k < 8; k++) add(1,1,1,8'hFF,0,0, 1,pat[7-k],0,1,0,8'h00);
      add(1,1,1,8'hFF,0,0, 0,0,1,0,0,8'h00);
      for (int k = 0; k < 8; k++) add(1,0,0,8'h00,0,0, 1,1,0,1,0,8'h00);
      add(1,0,0,8'h00,0,0, 0,0,1,0,0,8'h00);
      // write 0x00 then read 0x5A with a turnaround
      add(1,1,1,8'h00,0,0, 0,0,1,0,0,8'h00);
      for (int k = 0; k < 8; k++) add(1,0,0,8'h00,0,0, 1,0,0,1,0,8'h00);
      add(1,1,0,8'hEE,0,0, 0,0,1,0,0,8'h00);
      for (int k = 0; k < 2; k++) add(1,0,0,8'h00,0,0, 0,0,0,1,0,8'h00);
      pat = 8'h5A;
      for (int k = 0; k < 8; k++) add(1,0,0,8'h00,1,pat[7-k], 0,0,0,1,0,8'h00);
      add(1,0,0,8'h00,1,0, 0,0,0,1,1,8'h5A);
      add(1,0,0,8'h00,0,0, 0,0,1,0,0,8'h5A);

      for (int i = 0; i < vt.size(); i++) begin
         rst_n = vt[i].rn; cmd_valid = vt[i].cv; cmd_write = vt[i].cw; cmd_wdata = vt[i].wd;
         rsp_ready = vt[i].rr; data_in = vt[i].din;
         #1;
         check($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
         tick();
      end

      // read 0xC3 with rsp_ready held low for 5 cycles and cmd_valid kept high
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_wdata = 8'h77; rsp_ready = 1'b0; data_in = 1'b0;
      #1;
      check("bp_accept_rdy", 32'(cmd_ready), 32'd1);
      tick();
      pat = 8'hC3;
      for (int k = 0; k < 8; k++) begin
         data_in = pat[7-k];
         check($sformatf("bp_rx%0d", k), 32'({direction, busy, rsp_valid}), 32'b010);
         tick();
      end
      data_in = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_hold%0d", k), 32'({rsp_valid, rsp_rdata, cmd_ready, busy}), {22'd0, 1'b1, 8'hC3, 1'b0, 1'b1});
         tick();
      end
      rsp_ready = 1'b1;
      check("bp_release", 32'({rsp_valid, rsp_rdata}), {23'd0, 1'b1, 8'hC3});
      tick();
      cmd_valid = 1'b0; rsp_ready = 1'b0;
      check("bp_idle", 32'({rsp_valid, cmd_ready, busy}), 32'b010);
      tick();
      check("bp_no_new_cmd", 32'({busy, direction}), 32'b00);

      // reset during TX bit 4 of write 0xF0 (last op was a read, so turnaround first)
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wdata = 8'hF0;
      #1;
      check("rst_accept_rdy", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0; cmd_wdata = 8'h00;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_turn%0d", k), 32'({direction, busy}), 32'b01);
         tick();
      end
      pat = 8'hF0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rst_tx%0d", k), 32'({direction, data_out}), 32'({1'b1, pat[7-k]}));
         tick();
      end
      check("rst_tx4", 32'({direction, data_out, busy}), 32'b101);
      rst_n = 1'b0;
      tick();
      check("rst_after", 32'({direction, data_out, busy, rsp_valid, rsp_rdata}), 32'd0);
      rst_n = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0;
      #1;
      check("rst_read_rdy", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      pat = 8'h96;
      for (int k = 0; k < 8; k++) begin
         data_in = pat[7-k];
         check($sformatf("rst_rx%0d", k), 32'({direction, busy, rsp_valid}), 32'b010);
         tick();
      end
      data_in = 1'b0; rsp_ready = 1'b1;
      check("rst_rsp", 32'({rsp_valid, rsp_rdata}), {23'd0, 1'b1, 8'h96});
      tick();
      rsp_ready = 1'b0;
      check("rst_end_idle", 32'({rsp_valid, cmd_ready, busy}), 32'b010);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/bdir_line_ctrl.md
Name: bdir_line_ctrl

Overview:
- Half-duplex line controller that drives the control side of the bidirectional buffer interface.
- Outputs `direction` and `data_out` to the buffer and samples `data_in` from it.
- Converts parallel write/read commands into MSB-first serial bit streams on the shared `data_line`.
- Inserts bus-turnaround guard cycles whenever the transfer direction changes. Sits between a parallel command source and the buffer.

Parameters:
- WIDTH, 8, bits per transfer (>=2).
- TURN_CYCLES, 2, released-bus guard cycles inserted on a direction change (>=1).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  controller can accept a command.
- cmd_write  input  1  1 = write (drive line), 0 = read (sample line).
- cmd_wdata  input  WIDTH  write data; captured at acceptance.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer accepts read data.
- rsp_rdata  output  WIDTH  read data.
- direction  output  1  to buffer; 1 = drive `data_line`, 0 = released.
- data_out  output  1  to buffer; serial write bit.
- data_in  input  1  from buffer; serial read bit.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs and state registers take their reset values on the first rising edge with `rst_n`=0, regardless of the current state.
  - State=IDLE; `direction`=0, `data_out`=0, `rsp_valid`=0, `rsp_rdata`=0, `busy`=0.
  - `cmd_ready`=1 once `rst_n` is high; last_op=READ.
- Handshake:
  - A command is accepted on a cycle where `cmd_valid` && `cmd_ready` are both high.
  - `cmd_ready`=1 only in IDLE.
  - Command fields are registered at acceptance; later changes to `cmd_*` are ignored.
- States: IDLE, TURN, TX, RX, RESP.
- IDLE -> TURN if the accepted op differs from last_op; otherwise IDLE -> TX (write) or IDLE -> RX (read).
- TURN:
  - Lasts exactly TURN_CYCLES cycles; `direction`=0, `data_out`=0.
  - Then -> TX or RX per the registered op. last_op updates on leaving TURN.
- TX:
  - WIDTH cycles; `direction`=1.
  - `data_out`=cmd_wdata[WIDTH-1-k] on the k-th TX cycle (MSB first).
  - Then -> IDLE; `direction` returns to 0 in IDLE. last_op=WRITE.
- RX:
  - WIDTH cycles; `direction`=0.
  - `data_in` is sampled on each rising edge within RX and shifted in MSB first.
  - After the WIDTH-th sample -> RESP. last_op=READ.
- RESP:
  - `rsp_valid`=1 and `rsp_rdata` are held stable until `rsp_ready`=1. `cmd_ready`=0 throughout.
  - On `rsp_valid` && `rsp_ready` -> IDLE, and `rsp_valid` drops the next cycle.
- Latency:
  - Write accepted at cycle T: first bit at T+1, or T+1+TURN_CYCLES if a turnaround is needed; last bit WIDTH-1 cycles after the first.
  - Read accepted at T: `rsp_valid` rises WIDTH+1 cycles after acceptance with no turnaround, or WIDTH+1+TURN_CYCLES with a turnaround.
- Back-to-back same-direction ops: exactly one IDLE cycle (`direction`=0) between them; no guard is inserted.
- `direction` is never 1 outside TX. `direction` must never go 1 in the cycle immediately after RX.
- Counters: the bit counter has width ceil(log2(WIDTH)); the turn counter has width ceil(log2(TURN_CYCLES+1)). Neither wraps within a state.
- Reset mid-operation: any partial shift data is discarded; no response is produced for the aborted op.

Test Plan:
- Reset, then write 0xA5 accepted at cycle 0 (WIDTH=8, TURN_CYCLES=2):
  - cycles 1-2: `direction`=0;
  - cycles 3-10: `direction`=1, `data_out` = 1,0,1,0,0,1,0,1;
  - cycle 11: `direction`=0, `cmd_ready`=1.
- Write 0x3C, then write 0xFF presented immediately: no TURN before the second write; one `direction`=0 IDLE cycle between them; bits 00111100 then 11111111.
- Write 0x00, then read with `data_in` driven 0,1,0,1,1,0,1,0 during RX:
  - 2 TURN cycles with `direction`=0;
  - 8 RX cycles with `direction`=0;
  - `rsp_valid`=1 with `rsp_rdata`=0x5A.
- Read completes with `rsp_ready` held low for 5 cycles and `cmd_valid`=1 throughout: `rsp_valid`/`rsp_rdata` stable, `cmd_ready`=0, no new command accepted. Release `rsp_ready` -> one handshake, then IDLE.
- Assert `rst_n`=0 during TX bit 4 of write 0xF0:
  - next cycle `direction`=0, `data_out`=0, `busy`=0, `rsp_valid`=0;
  - after reset, a read is accepted and goes straight to RX with no TURN, since last_op=READ.
